// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer control block and its counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_ctrl_pkg;

    localparam int PRESCALE_W = 8;

    // Counter direction encoding, identical to the attached counter's dir input
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width-independent part of the shadowed configuration
    typedef struct packed {
        logic                  oneshot;
        logic                  dir;
        logic [PRESCALE_W-1:0] prescale;
    } cfg_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// Control bus between the timer FSM (master) and the up/down counter (slave).
// Latency: wires only.
// Backpressure: none; the counter acts on enable/load every cycle.
interface timer_ctrl_if #(
    parameter int counter_size = 8
);
    logic                    cnt_enable;
    logic                    cnt_load;
    logic                    cnt_dir;
    logic [counter_size-1:0] cnt_load_val;
    logic [counter_size-1:0] cnt_value;

    modport master (
        output cnt_enable,
        output cnt_load,
        output cnt_dir,
        output cnt_load_val,
        input  cnt_value
    );

    modport slave (
        input  cnt_enable,
        input  cnt_load,
        input  cnt_dir,
        input  cnt_load_val,
        output cnt_value
    );
endinterface

// File: rtl/timer_ctrl_prescaler.sv
// Prescaler: signals a counter step every (limit+1) advance cycles.
// Latency: o_match is combinational from the registered pre-count.
// Backpressure: none; i_clr wins over i_adv.
module timer_ctrl_prescaler
    import timer_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  i_clr,
    input  logic                  i_adv,
    input  logic [PRESCALE_W-1:0] i_limit,
    output logic                  o_match
);

    logic [PRESCALE_W-1:0] r_pre_cnt;

    assign o_match = (r_pre_cnt == i_limit);

    // Pre-count: cleared on (re)load, wraps to zero on the step cycle
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_pre_cnt <= '0;
        end else if (i_clr) begin
            r_pre_cnt <= '0;
        end else if (i_adv) begin
            r_pre_cnt <= o_match ? '0 : r_pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer FSM driving an external up/down counter (prescale, oneshot/periodic, tick, irq).
// Latency: start -> LOAD next cycle; tick is registered one cycle after terminal detect; irq one after tick.
// Backpressure: none; start is ignored while busy, stop aborts immediately and wins over start.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int counter_size = 8
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    oneshot,
    input  logic                    dir_cfg,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [counter_size-1:0] reload_val,
    input  logic [counter_size-1:0] terminal_val,
    input  logic                    irq_clr,
    timer_ctrl_if.master            cnt_bus,
    output logic                    tick,
    output logic                    irq,
    output logic                    busy
);

    state_t                  r_state;
    cfg_t                    r_cfg;
    logic [counter_size-1:0] r_reload_s;
    logic [counter_size-1:0] r_terminal_s;
    logic                    r_tick;
    logic                    r_irq;

    logic w_term;
    logic w_pre_match;
    logic w_pre_clr;
    logic w_pre_adv;

    // Terminal compare only matters while running; it takes precedence over stepping
    assign w_term    = (r_state == RUN) && (cnt_bus.cnt_value == r_terminal_s);
    assign w_pre_clr = (r_state == LOAD);
    assign w_pre_adv = (r_state == RUN) && !w_term;

    timer_ctrl_prescaler u_prescaler (
        .clk     (clk),
        .res_n   (res_n),
        .i_clr   (w_pre_clr),
        .i_adv   (w_pre_adv),
        .i_limit (r_cfg.prescale),
        .o_match (w_pre_match)
    );

    // Counter controls: load in LOAD, step on prescaler match in RUN, all gated off by stop
    assign cnt_bus.cnt_load     = !stop && (r_state == LOAD);
    assign cnt_bus.cnt_enable   = !stop && ((r_state == LOAD) ||
                                            ((r_state == RUN) && !w_term && w_pre_match));
    assign cnt_bus.cnt_dir      = r_cfg.dir;
    assign cnt_bus.cnt_load_val = r_reload_s;

    assign tick = r_tick;
    assign irq  = r_irq;
    assign busy = (r_state == LOAD) || (r_state == RUN);

    // Main FSM with config shadow capture and terminal-count tick generation
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state      <= IDLE;
            r_cfg        <= '0;
            r_reload_s   <= '0;
            r_terminal_s <= '0;
            r_tick       <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (stop) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (start) begin
                            r_cfg        <= '{oneshot: oneshot, dir: dir_cfg, prescale: prescale};
                            r_reload_s   <= reload_val;
                            r_terminal_s <= terminal_val;
                            r_state      <= LOAD;
                        end
                    end
                    LOAD: r_state <= RUN;
                    RUN: begin
                        if (w_term) begin
                            r_tick  <= 1'b1;
                            r_state <= r_cfg.oneshot ? DONE : LOAD;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Sticky interrupt: a tick wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_irq <= 1'b0;
        end else if (r_tick) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control FSM that sits directly upstream of the generic up/down counter and drives its enable, load, dir and cnt_in inputs.
- Consumes the counter's cnt_out as cnt_value.
- Turns the plain counter into a programmable timer: shadowed configuration, an 8-bit prescaler, one-shot or periodic auto-reload, a terminal-count tick and a sticky interrupt flag.

Parameters:
- counter_size, 8, width of the attached counter and of the reload_val / terminal_val / cnt_value buses.

Ports:
- clk  input  1  system clock; all logic on posedge.
- res_n  input  1  synchronous active-low reset.
- start  input  1  level-sampled; in IDLE or DONE, captures config and starts the timer.
- stop  input  1  aborts any activity and returns to IDLE; priority over start.
- oneshot  input  1  1 = stop after the first terminal count; 0 = periodic auto-reload.
- dir_cfg  input  1  0 = count up, 1 = count down; same encoding as the counter's dir.
- prescale  input  8  counter step every prescale+1 cycles.
- reload_val  input  counter_size  value loaded into the counter at every (re)start.
- terminal_val  input  counter_size  terminal count.
- irq_clr  input  1  clears irq.
- cnt_value  input  counter_size  counter's cnt_out.
- cnt_enable  output  1  to counter enable.
- cnt_load  output  1  to counter load.
- cnt_dir  output  1  to counter dir.
- cnt_load_val  output  counter_size  to counter cnt_in.
- tick  output  1  registered one-cycle pulse per terminal count.
- irq  output  1  sticky; set by tick.
- busy  output  1  high in LOAD or RUN.

Behaviour:
- Reset:
  - State = IDLE; shadow registers, pre_cnt, tick and irq = 0.
  - cnt_enable = cnt_load = 0.
  - cnt_dir and cnt_load_val come from the shadow registers, so they are 0.
- Shadow capture:
  - On accepted start, register oneshot, dir_cfg, prescale, reload_val and terminal_val.
  - Config inputs are ignored at all other times.
  - cnt_dir = dir_s; cnt_load_val = reload_s.
- States IDLE, LOAD, RUN, DONE:
  - cnt_enable/cnt_load are combinational from state and pre_cnt.
  - IDLE: outputs low. start & !stop -> capture, go to LOAD.
  - LOAD: cnt_enable = 1, cnt_load = 1 for exactly one cycle; pre_cnt <= 0; go to RUN.
  - RUN, terminal detect (cnt_value == terminal_s):
    - Checked first; cnt_enable = 0 that cycle and tick is set next cycle.
    - Periodic -> LOAD. Oneshot -> DONE.
  - RUN, no terminal:
    - If pre_cnt == prescale_s: cnt_enable = 1, cnt_load = 0, pre_cnt <= 0.
    - Else pre_cnt <= pre_cnt + 1.
  - DONE: outputs low, counter holds its value. start & !stop -> capture, go to LOAD.
  - start while in LOAD or RUN is ignored.
- stop: in any state, next state is IDLE. cnt_enable/cnt_load are forced 0 in the same cycle. The counter holds its value.
- Timing, with N = steps from reload to terminal modulo 2^counter_size in dir_s and P = prescale:
  - start sampled in cycle 0 -> LOAD cycle 1 -> RUN cycle 2, with cnt_value = reload.
  - First tick in cycle N(P+1)+3.
  - Periodic tick spacing is N(P+1)+2 cycles.
- Boundaries:
  - reload == terminal: N = 0, tick in cycle 3; periodic spacing 2.
  - Wrap-around past all-ones or zero is normal modulo counting. The counter's overflow output is not used.
  - irq: set on tick, cleared on irq_clr. Simultaneous tick and irq_clr -> irq stays 1.
  - Reset mid-RUN: immediate return to reset values. The counter is reset by the same res_n.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3;
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1, shared with the counter;
  - PRESCALE_W = 8.
- Natural sub-module: timer_prescaler, which holds pre_cnt, the compare and a clear input.
- Integration top instantiates timer_ctrl plus counter.

Test Plan:
- Test 1, basic oneshot:
  - Stimulus: counter_size = 8; reload = 0, terminal = 3, up, P = 0, oneshot = 1; start in cycle 0.
  - Required: tick in cycle 6 only; state DONE; cnt_value stays 3; irq = 1; busy low from cycle 6.
- Test 2, periodic with prescale: reload = 10, terminal = 6, down, P = 2, periodic -> ticks at cycles 15, 29, 43; cnt_value reloads to 10 after each tick.
- Test 3, down-count wrap-around: reload = 2, terminal = 254, down, P = 0 -> N = 4; first tick in cycle 7.
- Test 4, stop and restart:
  - Stimulus: stop asserted with start in the same cycle during RUN; later, start again with new config.
  - Required: IDLE next cycle, no tick, cnt_enable low. The new config is captured and old shadow values are not used.
- Test 5, irq and reload == terminal:
  - Stimulus: irq_clr asserted in the same cycle as a tick.
  - Required: irq remains 1; a later irq_clr alone clears it. reload == terminal with periodic mode gives a tick every 2 cycles.
- Test 6, reset mid-RUN: res_n low for 1 cycle -> all outputs 0 and state IDLE on the next edge; start is ignored while res_n = 0.
